// File: rtl/phys_reg_free_list_if.sv
// Rename/retire port bundle for the physical register free list.
// The master side is rename (pop) plus ROB retirement (push); the slave side is the list itself.
interface phys_reg_free_list_if #(
    parameter int REG_FILE_ADDR_WIDTH = 7
);
    logic                           alloc_en;
    logic                           alloc_valid;
    logic [REG_FILE_ADDR_WIDTH-1:0] alloc_reg;
    logic                           free_en;
    logic [REG_FILE_ADDR_WIDTH-1:0] free_reg;
    logic [REG_FILE_ADDR_WIDTH:0]   free_count;
    logic                           empty;
    logic                           full;
    logic                           error;

    modport master (
        output alloc_en, free_en, free_reg,
        input  alloc_valid, alloc_reg, free_count, empty, full, error
    );

    modport slave (
        input  alloc_en, free_en, free_reg,
        output alloc_valid, alloc_reg, free_count, empty, full, error
    );
endinterface

// File: rtl/phys_reg_free_list.sv
// Circular FIFO of free physical register numbers.
// Membership bits catch double frees; protocol violations raise a sticky error flag.
module phys_reg_free_list #(
    parameter int REG_FILE_ADDR_WIDTH = 7,
    parameter int ARCH_REGS           = 32
) (
    input  logic                clock,
    input  logic                reset,
    phys_reg_free_list_if.slave fl
);
    localparam int PHYS_REGS = 2 ** REG_FILE_ADDR_WIDTH;
    localparam int W         = REG_FILE_ADDR_WIDTH;

    logic [W-1:0]         entry [PHYS_REGS];
    logic [W-1:0]         head;
    logic [W-1:0]         tail;
    logic [W:0]           count;
    logic [PHYS_REGS-1:0] in_list;
    logic                 error_q;

    logic list_empty;
    logic list_full;
    logic do_pop;
    logic pop_err;
    logic push_req;
    logic do_push;
    logic dbl_free;
    logic ovf_free;

    assign list_empty = (count == '0);
    assign list_full  = (count == (W+1)'(PHYS_REGS - 1));

    assign fl.alloc_reg   = entry[head];
    assign fl.alloc_valid = !list_empty;
    assign fl.free_count  = count;
    assign fl.empty       = list_empty;
    assign fl.full        = list_full;
    assign fl.error       = error_q;

    assign do_pop   = fl.alloc_en && !list_empty;
    assign pop_err  = fl.alloc_en && list_empty;

    // Membership is checked against pre-edge state, so freeing the register
    // being popped this same cycle is treated as a double free.
    assign push_req = fl.free_en && (fl.free_reg != '0);
    assign dbl_free = push_req && in_list[fl.free_reg];
    assign ovf_free = push_req && !in_list[fl.free_reg] && list_full;
    assign do_push  = push_req && !in_list[fl.free_reg] && !list_full;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < PHYS_REGS; i++) begin
                if (i < PHYS_REGS - ARCH_REGS)
                    entry[i] <= W'(i + ARCH_REGS);
                else
                    entry[i] <= '0;
                in_list[i] <= (i >= ARCH_REGS);
            end
            head    <= '0;
            tail    <= W'(PHYS_REGS - ARCH_REGS);
            count   <= (W+1)'(PHYS_REGS - ARCH_REGS);
            error_q <= 1'b0;
        end else begin
            if (do_pop) begin
                head                  <= head + 1'b1;
                in_list[fl.alloc_reg] <= 1'b0;
            end
            if (do_push) begin
                entry[tail]          <= fl.free_reg;
                tail                 <= tail + 1'b1;
                in_list[fl.free_reg] <= 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (pop_err || dbl_free || ovf_free)
                error_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_phys_reg_free_list.sv
// Directed self-checking bench for the physical register free list.
module tb_phys_reg_free_list;
    logic clock = 1'b0;
    logic reset = 1'b1;

    int n_cmp = 0;
    int n_err = 0;

    phys_reg_free_list_if #(.REG_FILE_ADDR_WIDTH(7)) fl_if ();

    phys_reg_free_list #(.REG_FILE_ADDR_WIDTH(7), .ARCH_REGS(32)) dut (
        .clock (clock),
        .reset (reset),
        .fl    (fl_if.slave)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle();
        fl_if.alloc_en = 1'b0;
        fl_if.free_en  = 1'b0;
        fl_if.free_reg = '0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic free_one(input int r);
        fl_if.alloc_en = 1'b0;
        fl_if.free_en  = 1'b1;
        fl_if.free_reg = 7'(r);
        tick();
        idle();
    endtask

    task automatic pop_one();
        fl_if.alloc_en = 1'b1;
        fl_if.free_en  = 1'b0;
        tick();
        idle();
    endtask

    initial begin
        int exp_reg;
        idle();

        // Reset state
        do_reset();
        check("rst_valid", fl_if.alloc_valid, 1);
        check("rst_reg",   fl_if.alloc_reg,   32);
        check("rst_count", fl_if.free_count,  96);
        check("rst_empty", fl_if.empty,       0);
        check("rst_full",  fl_if.full,        0);
        check("rst_error", fl_if.error,       0);

        // Drain all 96 free registers in order
        for (int i = 0; i < 96; i++) begin
            check("drain_seq", fl_if.alloc_reg, 32 + i);
            pop_one();
        end
        check("drain_valid", fl_if.alloc_valid, 0);
        check("drain_empty", fl_if.empty,       1);
        check("drain_count", fl_if.free_count,  0);
        check("drain_error", fl_if.error,       0);

        // Refill from empty with 5 then 9
        free_one(5);
        check("refill1_reg",   fl_if.alloc_reg,   5);
        check("refill1_valid", fl_if.alloc_valid, 1);
        free_one(9);
        check("refill2_reg",   fl_if.alloc_reg,  5);
        check("refill2_count", fl_if.free_count, 2);
        pop_one();
        check("refill_pop1", fl_if.alloc_reg, 9);
        pop_one();
        check("refill_pop2_count", fl_if.free_count, 0);
        check("refill_error",      fl_if.error,      0);

        // Pop refused while empty, simultaneous push still lands
        fl_if.alloc_en = 1'b1;
        fl_if.free_en  = 1'b1;
        fl_if.free_reg = 7'd12;
        tick();
        idle();
        check("emptypop_error", fl_if.error,      1);
        check("emptypop_count", fl_if.free_count, 1);
        check("emptypop_reg",   fl_if.alloc_reg,  12);

        // Simultaneous pop and push after reset
        do_reset();
        fl_if.alloc_en = 1'b1;
        fl_if.free_en  = 1'b1;
        fl_if.free_reg = 7'd7;
        tick();
        idle();
        check("simul_count", fl_if.free_count, 96);
        check("simul_reg",   fl_if.alloc_reg,  33);
        for (int i = 0; i < 95; i++) pop_one();
        check("simul_seven", fl_if.alloc_reg,  7);
        check("simul_cnt1",  fl_if.free_count, 1);
        check("simul_err",   fl_if.error,      0);
        pop_one();
        check("simul_empty", fl_if.empty, 1);

        // Head and tail wrap past 127
        for (int r = 1; r <= 31; r++) free_one(r);
        check("wrap_count", fl_if.free_count, 31);
        for (int r = 1; r <= 31; r++) begin
            check("wrap_seq", fl_if.alloc_reg, r);
            pop_one();
        end
        check("wrap_empty", fl_if.empty, 1);
        check("wrap_error", fl_if.error, 0);

        // Double free is dropped and error is sticky
        do_reset();
        free_one(40);
        check("dbl_count", fl_if.free_count, 96);
        check("dbl_error", fl_if.error,      1);
        check("dbl_reg",   fl_if.alloc_reg,  32);
        tick();
        tick();
        check("dbl_sticky", fl_if.error, 1);

        // Freeing x0 is silently ignored
        do_reset();
        free_one(0);
        check("x0_count", fl_if.free_count, 96);
        check("x0_error", fl_if.error,      0);

        // Freeing the register being popped in the same cycle
        do_reset();
        fl_if.alloc_en = 1'b1;
        fl_if.free_en  = 1'b1;
        fl_if.free_reg = 7'd32;
        tick();
        idle();
        check("samepop_count", fl_if.free_count, 95);
        check("samepop_error", fl_if.error,      1);
        check("samepop_reg",   fl_if.alloc_reg,  33);

        // Fill to full, then drain and pop while empty
        do_reset();
        for (int r = 5; r <= 31; r++) free_one(r);
        check("fill123_count", fl_if.free_count, 123);
        check("fill123_full",  fl_if.full,       0);
        for (int r = 1; r <= 4; r++) free_one(r);
        check("full_count", fl_if.free_count, 127);
        check("full_flag",  fl_if.full,       1);
        check("full_error", fl_if.error,      0);
        for (int i = 0; i < 127; i++) begin
            if (i < 96)       exp_reg = 32 + i;
            else if (i < 123) exp_reg = 5 + (i - 96);
            else              exp_reg = 1 + (i - 123);
            check("full_drain_seq", fl_if.alloc_reg, exp_reg);
            pop_one();
        end
        check("full_drain_empty", fl_if.empty, 1);
        check("full_drain_error", fl_if.error, 0);
        pop_one();
        check("underflow_error", fl_if.error,      1);
        check("underflow_count", fl_if.free_count, 0);

        // Mid-sequence reset with stimulus active
        do_reset();
        free_one(40);
        for (int i = 0; i < 10; i++) pop_one();
        free_one(2);
        free_one(3);
        free_one(4);
        check("mid_pre_count", fl_if.free_count, 89);
        check("mid_pre_error", fl_if.error,      1);
        fl_if.alloc_en = 1'b1;
        fl_if.free_en  = 1'b1;
        fl_if.free_reg = 7'd5;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle();
        check("mid_reg",   fl_if.alloc_reg,  32);
        check("mid_count", fl_if.free_count, 96);
        check("mid_error", fl_if.error,      0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
